// File: rtl/snn_timestep_scheduler.sv
// Frame/timestep sequencer for the SNN pipeline: starts the spike source,
// drains each layer in order, commands fire/leak, and guards every wait.
module snn_timestep_scheduler #(
  parameter int N_LAYERS    = 3,
  parameter int TS_WIDTH    = 2,
  parameter int DRAIN_GUARD = 4,
  parameter int TIMEOUT     = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [TS_WIDTH-1:0] cfg_last_ts,
  input  logic                src_done,
  input  logic [N_LAYERS-1:0] fifo_empty,
  input  logic [N_LAYERS-1:0] layer_busy,
  input  logic [N_LAYERS-1:0] layer_ack,
  output logic                src_go,
  output logic [TS_WIDTH-1:0] timestep,
  output logic [N_LAYERS-1:0] layer_ts_end,
  output logic                frame_done,
  output logic                busy,
  output logic                err_timeout
);

  localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_DRAIN,
    S_FIRE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [3:0]          r_q;
  logic [15:0]         r_wd;
  logic [TS_WIDTH-1:0] r_ts;
  logic [TS_WIDTH-1:0] r_last;
  logic                r_src_go;
  logic [N_LAYERS-1:0] r_ts_end;
  logic                r_done;
  logic                r_busy;
  logic                r_err;

  logic                w_quiet;
  logic                w_ack;
  logic                w_last_k;
  logic                w_last_ts;
  logic                w_wd_exp;
  logic                w_q_full;
  logic [N_LAYERS-1:0] w_sel;

  assign w_quiet   = fifo_empty[r_k] & ~layer_busy[r_k];
  assign w_ack     = layer_ack[r_k];
  assign w_last_k  = (r_k == KW'(N_LAYERS - 1));
  assign w_last_ts = (r_ts == r_last);
  assign w_wd_exp  = (r_wd == 16'(TIMEOUT - 1));
  assign w_q_full  = (r_q == 4'(DRAIN_GUARD - 1));

  always_comb begin
    w_sel      = '0;
    w_sel[r_k] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_q      <= '0;
      r_wd     <= '0;
      r_ts     <= '0;
      r_last   <= '0;
      r_src_go <= 1'b0;
      r_ts_end <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_src_go <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (frame_start) begin
            r_last   <= cfg_last_ts;
            r_ts     <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_src_go <= 1'b1;
            r_state  <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_wd_exp) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_wd    <= '0;
            r_state <= S_IDLE;
          end else if (src_done) begin
            r_k     <= '0;
            r_q     <= '0;
            r_wd    <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_DRAIN: begin
          if (w_wd_exp) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_wd    <= '0;
            r_state <= S_IDLE;
          end else if (w_quiet && w_q_full) begin
            r_ts_end <= w_sel;
            r_wd     <= '0;
            r_state  <= S_FIRE;
          end else begin
            // any busy/non-empty cycle restarts the quiet window
            r_q  <= w_quiet ? r_q + 4'd1 : 4'd0;
            r_wd <= r_wd + 16'd1;
          end
        end
        S_FIRE: begin
          if (w_wd_exp) begin
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_ts_end <= '0;
            r_wd     <= '0;
            r_state  <= S_IDLE;
          end else if (w_ack) begin
            r_ts_end <= '0;
            r_wd     <= '0;
            if (!w_last_k) begin
              r_k     <= r_k + KW'(1);
              r_q     <= '0;
              r_state <= S_DRAIN;
            end else if (!w_last_ts) begin
              r_ts     <= r_ts + TS_WIDTH'(1);
              r_src_go <= 1'b1;
              r_state  <= S_EMIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_wd    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign src_go       = r_src_go;
  assign timestep     = r_ts;
  assign layer_ts_end = r_ts_end;
  assign frame_done   = r_done;
  assign busy         = r_busy;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Bench for snn_timestep_scheduler: table of frames plus hand-written
// glitch, stray-event, watchdog and mid-frame reset sequences.
module tb_snn_timestep_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [1:0] cfg_last_ts;
  logic       src_done;
  logic [2:0] fifo_empty;
  logic [2:0] layer_busy;
  logic [2:0] layer_ack;
  logic       src_go;
  logic [1:0] timestep;
  logic [2:0] layer_ts_end;
  logic       frame_done;
  logic       busy;
  logic       err_timeout;

  snn_timestep_scheduler #(
    .N_LAYERS(3), .TS_WIDTH(2), .DRAIN_GUARD(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .cfg_last_ts(cfg_last_ts), .src_done(src_done),
    .fifo_empty(fifo_empty), .layer_busy(layer_busy),
    .layer_ack(layer_ack), .src_go(src_go), .timestep(timestep),
    .layer_ts_end(layer_ts_end), .frame_done(frame_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;
    logic [2:0] sel;
    logic [1:0] ts;
  } ev_t;

  typedef struct {
    logic [1:0] last;
    int         go;
    int         cmd;
    int         lat;
  } vec_t;

  ev_t  sbq[$];
  vec_t vt[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_go, n_cmd, n_done;
  logic [2:0] prev_cmd = '0;
  int cmd_age = 0;
  bit auto_src = 1;
  bit glitch_arm = 0;
  int glitch_cyc = -10;
  int rise_exp = -10;
  bit stray_en = 0;
  int stray_cyc = -10;
  logic [1:0] stray_ts;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic obs(input logic [1:0] kind, input logic [2:0] sel,
                     input logic [1:0] ts);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected actual kind=%0d sel=%b ts=%0d required=none",
               kind, sel, ts);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.sel != sel || e.ts != ts) begin
        failures++;
        $display("FAIL sb_event actual kind=%0d sel=%b ts=%0d required kind=%0d sel=%b ts=%0d",
                 kind, sel, ts, e.kind, e.sel, e.ts);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (src_go) begin
      n_go++;
      obs(2'd0, 3'b000, timestep);
    end
    if (layer_ts_end != 3'b000 && prev_cmd == 3'b000) begin
      n_cmd++;
      obs(2'd1, layer_ts_end, timestep);
      if (layer_ts_end == 3'b010 && rise_exp >= 0) begin
        chk("glitch_rise_cycle", cyc, rise_exp);
        rise_exp = -10;
      end
    end
    if (frame_done) begin
      n_done++;
      obs(2'd2, 3'b000, timestep);
    end
    if (cyc == stray_cyc + 1) begin
      frame_start = 1'b0;
      chk("stray_cmd_held", int'(layer_ts_end), 1);
      chk("stray_ts_same", int'(timestep), int'(stray_ts));
      chk("stray_no_go", int'(src_go), 0);
    end
    src_done = auto_src && src_go;
    if (layer_ts_end != 3'b000)
      cmd_age = (prev_cmd == 3'b000) ? 0 : cmd_age + 1;
    else
      cmd_age = 0;
    layer_ack = (layer_ts_end != 3'b000 && cmd_age == 1) ? layer_ts_end : 3'b000;
    if (glitch_arm && prev_cmd == 3'b001 && layer_ts_end == 3'b000) begin
      glitch_cyc = cyc + 3;
      rise_exp   = cyc + 8;
      glitch_arm = 0;
    end
    fifo_empty = 3'b111;
    if (cyc == glitch_cyc) fifo_empty[1] = 1'b0;
    if (stray_en && layer_ts_end == 3'b001 && prev_cmd == 3'b000) begin
      layer_ack[2] = 1'b1;
      frame_start  = 1'b1;
      stray_cyc    = cyc;
      stray_ts     = timestep;
      stray_en     = 0;
    end
    prev_cmd = layer_ts_end;
  endtask

  task automatic start_frame(input logic [1:0] last, output int n0);
    ev_t e;
    cfg_last_ts = last;
    frame_start = 1'b1;
    n_go = 0;
    n_cmd = 0;
    n_done = 0;
    for (int t = 0; t <= int'(last); t++) begin
      e.kind = 2'd0; e.sel = 3'b000; e.ts = 2'(t);
      sbq.push_back(e);
      for (int k = 0; k < 3; k++) begin
        e.kind = 2'd1; e.sel = 3'(1 << k); e.ts = 2'(t);
        sbq.push_back(e);
      end
    end
    e.kind = 2'd2; e.sel = 3'b000; e.ts = last;
    sbq.push_back(e);
    n0 = cyc;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget && lat < 0; i++) begin
      step();
      if (frame_done) lat = cyc - n0;
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_wait actual=none required=frame_done within %0d", budget);
    end
  endtask

  int n0, lat;

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    cfg_last_ts = '0;
    src_done = 1'b0;
    fifo_empty = 3'b111;
    layer_busy = 3'b000;
    layer_ack = 3'b000;
    vt[0] = '{2'd3, 4, 12, 77};
    vt[1] = '{2'd0, 1, 3, 20};
    vt[2] = '{2'd1, 2, 6, 39};
    vt[3] = '{2'd2, 3, 9, 58};

    repeat (3) step();
    chk("rst_src_go", int'(src_go), 0);
    chk("rst_timestep", int'(timestep), 0);
    chk("rst_ts_end", int'(layer_ts_end), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_timeout), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      start_frame(vt[i].last, n0);
      chk("busy_after_start", int'(busy), 1);
      wait_done(n0, 200, lat);
      chk("frame_latency", lat, vt[i].lat);
      step();
      chk("busy_after_done", int'(busy), 0);
      chk("go_count", n_go, vt[i].go);
      chk("cmd_count", n_cmd, vt[i].cmd);
      chk("done_count", n_done, 1);
      chk("sb_leftover", sbq.size(), 0);
      step();
    end

    glitch_arm = 1;
    start_frame(2'd0, n0);
    wait_done(n0, 100, lat);
    chk("glitch_latency", lat, 24);
    chk("glitch_checked", rise_exp, -10);
    step();
    step();

    stray_en = 1;
    start_frame(2'd1, n0);
    wait_done(n0, 100, lat);
    chk("stray_latency", lat, 39);
    step();
    chk("stray_go_count", n_go, 2);
    chk("stray_busy_end", int'(busy), 0);
    chk("stray_sb_leftover", sbq.size(), 0);
    step();

    auto_src = 0;
    start_frame(2'd1, n0);
    while (cyc < n0 + 16) step();
    chk("wd_busy_before", int'(busy), 1);
    chk("wd_err_before", int'(err_timeout), 0);
    step();
    chk("wd_busy_after", int'(busy), 0);
    chk("wd_err_after", int'(err_timeout), 1);
    repeat (10) step();
    chk("wd_no_done", n_done, 0);
    chk("wd_err_sticky", int'(err_timeout), 1);
    sbq.delete();
    auto_src = 1;
    start_frame(2'd0, n0);
    chk("wd_err_cleared", int'(err_timeout), 0);
    wait_done(n0, 100, lat);
    chk("wd_next_latency", lat, 20);
    step();
    step();

    start_frame(2'd3, n0);
    for (int i = 0; i < 120; i++) begin
      if (layer_ts_end == 3'b010 && timestep == 2'd2) break;
      step();
    end
    chk("mid_fire_reached", int'(layer_ts_end == 3'b010 && timestep == 2'd2), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_src_go", int'(src_go), 0);
    chk("mid_rst_timestep", int'(timestep), 0);
    chk("mid_rst_ts_end", int'(layer_ts_end), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(frame_done), 0);
    step();
    rst = 1'b0;
    sbq.delete();
    step();
    start_frame(2'd0, n0);
    wait_done(n0, 100, lat);
    chk("post_rst_latency", lat, 20);
    step();
    chk("post_rst_go", n_go, 1);
    chk("post_rst_cmd", n_cmd, 3);
    chk("post_rst_done", n_done, 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_sb_leftover", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_timestep_scheduler.md
# snn_timestep_scheduler

Frame/timestep sequencer for the SNN pipeline (spike source → input FIFO → conv layer → layer FIFO → fc layer). It starts the spike source for each timestep, then walks the layers in order. For each layer it waits until that layer's input FIFO and datapath are drained, then commands the end-of-timestep fire/leak. It repeats this for a configured number of timesteps per frame and reports frame completion or a watchdog timeout.

## Interface
Parameters:
- `N_LAYERS`, 3, number of sequenced stages (stage 0 = source-fed layer)
- `TS_WIDTH`, 2, timestep counter width (matches the existing 2-bit timestep_switch)
- `DRAIN_GUARD`, 4, consecutive quiet cycles required before declaring a stage drained (1..15)
- `TIMEOUT`, 65535, watchdog limit in cycles per wait state (fits 16 bits)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: asynchronous, active-high reset
- `frame_start` in 1: one-cycle request to run a frame; honoured only in IDLE
- `cfg_last_ts` in TS_WIDTH: index of last timestep (frame length = cfg_last_ts+1); sampled on accepted frame_start
- `src_done` in 1: source finished emitting the current timestep (pulse or level)
- `fifo_empty` in N_LAYERS: empty flag of the FIFO feeding stage k
- `layer_busy` in N_LAYERS: stage k has work in flight
- `layer_ack` in N_LAYERS: stage k finished its fire/leak step (one-cycle pulse)
- `src_go` out 1: one-cycle pulse, source begins current timestep
- `timestep` out TS_WIDTH: current timestep index
- `layer_ts_end` out N_LAYERS: one-hot level, fire/leak command to stage k, held until ack
- `frame_done` out 1: one-cycle pulse at frame end
- `busy` out 1: high in every state except IDLE
- `err_timeout` out 1: sticky watchdog error, cleared only by rst or accepted frame_start

## Operation
- FSM states: IDLE, EMIT, DRAIN, FIRE, DONE. Stage index `k` ranges 0..N_LAYERS-1. Timestep counter `ts`. Quiet counter `q`. Watchdog counter `wd`.
- IDLE: frame_start=1 → latch cfg_last_ts, ts←0, err_timeout←0, go to EMIT.
- EMIT: src_go=1 in the first EMIT cycle only. Wait for src_done=1 (src_done in the first EMIT cycle counts). Then k←0, q←0, go to DRAIN.
- DRAIN: quiet = fifo_empty[k] & ~layer_busy[k]. If quiet, q increments; otherwise q←0. When q reaches DRAIN_GUARD, go to FIRE.
- FIRE: layer_ts_end[k]=1 until layer_ack[k].
  - On ack, if k<N_LAYERS-1: k←k+1, q←0, go to DRAIN. Stage k's spikes now sit in FIFO k+1.
  - On ack, if k=N_LAYERS-1 and ts≠last: ts←ts+1, go to EMIT.
  - On ack, if k=N_LAYERS-1 and ts=last: go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE. ts holds the last value.
- Watchdog: wd clears on every state change and increments each cycle in EMIT/DRAIN/FIRE. When wd=TIMEOUT-1: err_timeout←1, all commands drop, go to IDLE. frame_done does not pulse.
- Ignored inputs: layer_ack on a non-selected stage, layer_ack outside FIRE, src_done outside EMIT, and frame_start outside IDLE.
- ts never wraps within a frame, because cfg_last_ts ≤ 2^TS_WIDTH-1.

## Timing
- Reset values: src_go=0, timestep=0, layer_ts_end=0, frame_done=0, busy=0, err_timeout=0. FSM goes to IDLE; k, q and wd go to 0.
- All outputs are registered and decoded from state; no input-to-output combinational path.
- frame_start at cycle n → busy and src_go high at n+1.
- src_done sampled at cycle m → DRAIN from m+1. With an already-quiet stage, layer_ts_end[k] rises at m+1+DRAIN_GUARD.
- layer_ack[k] at cycle a → layer_ts_end[k] low at a+1. At the same cycle a+1, one of these occurs: the next stage enters DRAIN, src_go pulses, or DONE is entered.
- frame_done occurs one cycle after the final ack. busy is low the cycle after frame_done.
- A quiet glitch (one non-quiet cycle) restarts the full DRAIN_GUARD count.
- rst asserted mid-frame forces reset values immediately, asynchronously. Stages must tolerate an unacked layer_ts_end dropping.

## Test plan
- Basic frame, all stages always quiet and acking 1 cycle after command, cfg_last_ts=3, DRAIN_GUARD=4 → four src_go pulses with timestep 0,1,2,3. Each timestep issues layer_ts_end 1,2,4 in order. One frame_done, then busy=0.
- Quiet glitch: fifo_empty[1] drops for 1 cycle after 3 quiet cycles → layer_ts_end[1] is delayed by exactly 4 cycles past the glitch.
- Simultaneous/stray events: layer_ack[2] during FIRE of stage 0, plus frame_start mid-frame → no state change, no new frame, timestep unchanged.
- Watchdog (TIMEOUT=16): src_done never arrives → err_timeout=1 and busy=0 at cycle 16 after EMIT entry, no frame_done. Next frame_start clears err_timeout.
- Reset mid-FIRE, stage 1, ts=2 → all outputs at reset values in the same cycle. After release, frame_start with cfg_last_ts=0 → exactly one timestep, then frame_done.
- Single-timestep frame, cfg_last_ts=0, N_LAYERS=3 → exactly 1 src_go, 3 commands, 1 frame_done. Timestep stays 0 throughout.
